// File: rtl/tw_mult_sec.sv
// tw_mult_sec: stage-2 twiddle consumer. Tracks the frame position, drives
// the twiddle ROM read port, aligns the registered ROM data with the delayed
// sample and performs a rounded, saturated Q1.12 complex rotation.
// Sample accepted in cycle t appears on out_* in cycle t+3.
module tw_mult_sec #(
    parameter int stage_FFT      = 2,
    parameter int SIZE           = 10,
    parameter int word_length_tw = 14,
    parameter int DW             = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_sop,
    input  logic signed [DW-1:0]             in_re,
    input  logic signed [DW-1:0]             in_im,
    output logic                             en_rd,
    output logic        [stage_FFT-2:0]      rd_ptr_angle,
    input  logic signed [word_length_tw-1:0] cos_data,
    input  logic signed [word_length_tw-1:0] sin_data,
    output logic                             out_valid,
    output logic                             out_sop,
    output logic                             out_last,
    output logic signed [DW-1:0]             out_re,
    output logic signed [DW-1:0]             out_im
);

    localparam int PW   = DW + word_length_tw;   // product width
    localparam int SW   = PW + 1;                // sum width
    localparam int FRAC = word_length_tw - 2;    // Q1.12 fraction bits

    localparam logic signed [SW-1:0] RND     = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Frame position tracking
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] idx;
    logic            last_flag;

    // P1: delayed sample and markers
    logic                 v1_q, sop1_q, last1_q;
    logic signed [DW-1:0] re1_q, im1_q;

    // P2: partial products
    logic                 v2_q, sop2_q, last2_q;
    logic signed [PW-1:0] p_rc_q, p_is_q, p_rs_q, p_ic_q;

    // P3 combinational: sums, rounding, saturation
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [SW-1:0] rnd_re, rnd_im;
    logic signed [DW-1:0] sat_re, sat_im;

    function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction

    // Effective index (in_sop resynchronises), ROM request and next count
    always_comb begin
        idx          = in_sop ? '0 : cnt_q;
        last_flag    = (idx == '1);
        cnt_d        = cnt_q;
        if (in_valid)
            cnt_d = idx + 1'b1;
        en_rd        = in_valid & rst_n;
        rd_ptr_angle = idx[stage_FFT-2:0];
    end

    // Frame counter, wraps naturally at 2^SIZE
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // P1: capture sample alongside the outstanding ROM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sop1_q  <= 1'b0;
            last1_q <= 1'b0;
            re1_q   <= '0;
            im1_q   <= '0;
        end else begin
            v1_q    <= in_valid;
            sop1_q  <= in_valid & in_sop;
            last1_q <= in_valid & last_flag;
            re1_q   <= in_re;
            im1_q   <= in_im;
        end
    end

    // P2: four signed products against the ROM data arriving this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sop2_q  <= 1'b0;
            last2_q <= 1'b0;
            p_rc_q  <= '0;
            p_is_q  <= '0;
            p_rs_q  <= '0;
            p_ic_q  <= '0;
        end else begin
            v2_q    <= v1_q;
            sop2_q  <= sop1_q;
            last2_q <= last1_q;
            p_rc_q  <= PW'(re1_q) * PW'(cos_data);
            p_is_q  <= PW'(im1_q) * PW'(sin_data);
            p_rs_q  <= PW'(re1_q) * PW'(sin_data);
            p_ic_q  <= PW'(im1_q) * PW'(cos_data);
        end
    end

    // P3 datapath: complex sums, round half up, saturate to DW bits
    always_comb begin
        sum_re = SW'(p_rc_q) - SW'(p_is_q);
        sum_im = SW'(p_rs_q) + SW'(p_ic_q);
        rnd_re = (sum_re + RND) >>> FRAC;
        rnd_im = (sum_im + RND) >>> FRAC;
        sat_re = saturate(rnd_re);
        sat_im = saturate(rnd_im);
    end

    // P3: registered outputs; data held across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= v2_q;
            out_sop   <= sop2_q;
            out_last  <= last2_q;
            if (v2_q) begin
                out_re <= sat_re;
                out_im <= sat_im;
            end
        end
    end

endmodule

// File: tb/tb_tw_mult_sec.sv
// Scoreboard bench for tw_mult_sec with a small frame (SIZE=3) and a
// registered two-entry twiddle ROM model.
module tb_tw_mult_sec;

    localparam int SIZE   = 3;
    localparam int FRAME  = 1 << SIZE;
    localparam int DW     = 16;
    localparam int WT     = 14;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_sop = 1'b0;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;
    logic                 en_rd;
    logic [0:0]           rd_ptr_angle;
    logic signed [WT-1:0] cos_data = '0;
    logic signed [WT-1:0] sin_data = '0;
    logic                 out_valid, out_sop, out_last;
    logic signed [DW-1:0] out_re, out_im;

    tw_mult_sec #(
        .stage_FFT      (2),
        .SIZE           (SIZE),
        .word_length_tw (WT),
        .DW             (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_re        (in_re),
        .in_im        (in_im),
        .en_rd        (en_rd),
        .rd_ptr_angle (rd_ptr_angle),
        .cos_data     (cos_data),
        .sin_data     (sin_data),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_last     (out_last),
        .out_re       (out_re),
        .out_im       (out_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Twiddle ROM: registered read, contents only changed while idle
    int rom_c [2];
    int rom_s [2];
    always @(posedge clk) begin
        if (en_rd) begin
            cos_data <= WT'(rom_c[rd_ptr_angle]);
            sin_data <= WT'(rom_s[rd_ptr_angle]);
        end
    end

    typedef struct {
        int cyc;
        int re;
        int im;
        bit sop;
        bit last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: exact complex product, round half up (floor of x+0.5), clamp
    function automatic int rot(input int a, input int b, input int c, input int s, input bit imag);
        longint p, r, d;
        p = imag ? (longint'(a) * s + longint'(b) * c) : (longint'(a) * c - longint'(b) * s);
        r = p + 2048;
        if (r >= 0) d = r / 4096;
        else        d = -((-r + 4095) / 4096);
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return int'(d);
    endfunction

    // One clock of stimulus; the model decides idx, twiddle and markers
    task automatic drive(input bit v, input bit sop, input int re, input int im, input bit rst = 1'b1);
        int idx;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rst;
        in_valid = v;
        in_sop   = sop;
        in_re    = DW'(re);
        in_im    = DW'(im);
        idx      = -1;
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else if (v) begin
            idx    = sop ? 0 : m_cnt;
            m_cnt  = (idx + 1) % FRAME;
            e.cyc  = cyc + 3;
            e.re   = rot(re, im, rom_c[idx % 2], rom_s[idx % 2], 1'b0);
            e.im   = rot(re, im, rom_c[idx % 2], rom_s[idx % 2], 1'b1);
            e.sop  = sop;
            e.last = (idx == FRAME - 1);
            q.push_back(e);
        end
        @(negedge clk);
        chk("en_rd", int'(en_rd), int'(v && rst));
        if (idx >= 0)
            chk("rd_ptr_angle", int'(rd_ptr_angle), idx % 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_sop"},   int'(out_sop),   0);
        chk({tag, "_last"},  int'(out_last),  0);
        chk({tag, "_re"},    int'(out_re),    0);
        chk({tag, "_im"},    int'(out_im),    0);
    endtask

    function automatic int rnd_data();
        case ($urandom_range(0, 9))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents a sample
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missing_output", 0, 1);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency",  cyc,            e.cyc);
                chk("out_re",   int'(out_re),   e.re);
                chk("out_im",   int'(out_im),   e.im);
                chk("out_sop",  int'(out_sop),  int'(e.sop));
                chk("out_last", int'(out_last), int'(e.last));
            end
        end
    end

    initial begin
        rom_c[0] = 4096; rom_s[0] = 0;
        rom_c[1] = 4096; rom_s[1] = 0;

        // Reset state
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 5, 5, 1'b0);
        drive(1'b0, 1'b0, 0, 0);
        check_zero("reset");

        // Identity rotation
        drive(1'b1, 1'b1, 1234, -567);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1234, -567);
        idle(5);

        // -j rotation at idx 1
        rom_c[1] = 0; rom_s[1] = -4096;
        drive(1'b1, 1'b1, 77, -88);
        drive(1'b1, 1'b0, 1000, 300);
        idle(5);

        // Saturating rotation at idx 1
        rom_c[1] = 0; rom_s[1] = 4096;
        drive(1'b1, 1'b1, 0, -32768);
        drive(1'b1, 1'b0, 0, -32768);
        rom_c[0] = 0; rom_s[0] = -4096;
        idle(5);
        drive(1'b1, 1'b1, -32768, -32768);
        idle(5);

        // Rounding: half-scale twiddle
        rom_c[0] = 2048; rom_s[0] = 0;
        rom_c[1] = 2048; rom_s[1] = 0;
        drive(1'b1, 1'b1, 3, -3);
        drive(1'b1, 1'b0, -3, 3);
        drive(1'b1, 1'b0, 1, -1);
        idle(5);

        // Frame markers: full frame then a ninth sample without sop
        rom_c[0] = 4096; rom_s[0] = 0;
        rom_c[1] = 2896; rom_s[1] = -2896;
        drive(1'b1, 1'b1, 100, 200);
        for (int i = 1; i < 9; i++) drive(1'b1, 1'b0, 100 * i, -50 * i);
        idle(5);

        // Bubbles
        drive(1'b1, 1'b1, 11, 12);
        drive(1'b0, 1'b1, 13, 14);
        drive(1'b1, 1'b0, 15, 16);
        drive(1'b1, 1'b0, 17, 18);
        idle(5);

        // Resync at idx 5, then a full frame to reach last
        drive(1'b1, 1'b1, 1, 2);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 3 + i, 4 + i);
        drive(1'b1, 1'b1, 9, 9);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 20 + i, -20 - i);
        idle(5);

        // Reset with three samples in flight
        drive(1'b1, 1'b1, 500, 600);
        drive(1'b1, 1'b0, 700, 800);
        drive(1'b1, 1'b0, 900, 1000, 1'b0);
        drive(1'b0, 1'b0, 0, 0);
        check_zero("post_reset");
        drive(1'b1, 1'b0, 321, -654);
        drive(1'b1, 1'b0, 111, 222);
        idle(5);

        // Randomised batches, ROM reloaded between batches
        for (int b = 0; b < 12; b++) begin
            for (int a = 0; a < 2; a++) begin
                rom_c[a] = int'($urandom_range(0, 16383)) - 8192;
                rom_s[a] = int'($urandom_range(0, 16383)) - 8192;
            end
            for (int i = 0; i < 60; i++)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                      rnd_data(), rnd_data());
            idle(5);
        end

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
